// File: rtl/imem_loader.sv
// Boot loader: packs a big-endian byte stream into 32-bit words, writes them to imem from word 0,
// then verifies a trailing XOR checksum before releasing the CPU pipeline.
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   load_words,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] WONE    = (ADDR_W+1)'(1);

  state_t            state;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   widx;
  logic [1:0]        bcnt;
  logic [23:0]       shreg;
  logic [7:0]        xsum;
  logic              xfer;
  logic              len_ok;
  logic              sum_bad;

  assign byte_ready = (state == LOAD) || (state == CHECK);
  assign xfer       = byte_valid && byte_ready;
  assign len_ok     = (load_words != '0) && (load_words <= DEPTH_W);
  assign sum_bad    = (byte_data != xsum);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      len        <= '0;
      widx       <= '0;
      bcnt       <= '0;
      shreg      <= '0;
      xsum       <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            cpu_hold <= 1'b1;
            if (len_ok) begin
              state <= LOAD;
              len   <= load_words;
              widx  <= '0;
              bcnt  <= '0;
              xsum  <= '0;
              done  <= 1'b0;
              error <= 1'b0;
            end else begin
              state <= DONE;
              done  <= 1'b1;
              error <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (xfer) begin
            shreg <= {shreg[15:0], byte_data};
            xsum  <= xsum ^ byte_data;
            bcnt  <= bcnt + 2'd1;
            // Fourth byte completes a word: shreg already holds the first three, MSB first.
            if (bcnt == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= widx[ADDR_W-1:0];
              imem_wdata <= {shreg, byte_data};
              widx       <= widx + WONE;
              if (widx + WONE == len) state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (xfer) begin
            state    <= DONE;
            done     <= 1'b1;
            error    <= sum_bad;
            cpu_hold <= sum_bad;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
